// File: rtl/audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// audio_i2s_tx
//
// Consumer end of the stereo audio output FIFOs. It pops left/right samples
// in lockstep from two show-ahead FIFOs and saturates each sample to
// SAMPLE_BITS. It then serializes the pair as a standard I2S frame
// (bclk / lrclk / sdata) for an external DAC. Frames that go out without a
// fresh sample pair, once streaming has started, are counted as underruns.
//
// Parameters
//   DATA_SIZE   : FIFO sample width, signed.
//   SAMPLE_BITS : I2S word width per channel, signed, 2..DATA_SIZE.
//   BCLK_DIV    : system clocks per bclk half-period, >= 2.
//
// Ports
//   clock, reset              : system clock, synchronous active-high reset.
//   left_audio_dout/_empty    : left FIFO head (show-ahead) and empty flag.
//   left_audio_rd_en          : left FIFO pop.
//   right_audio_dout/_empty   : right FIFO head (show-ahead) and empty flag.
//   right_audio_rd_en         : right FIFO pop.
//   i2s_bclk                  : I2S bit clock.
//   i2s_lrclk                 : I2S word select, 0 = left, 1 = right.
//   i2s_sdata                 : I2S serial data, MSB first.
//   active                    : set once the first real pair was framed.
//   underrun_count            : saturating count of zero-filled frames
//                               after active.
// -----------------------------------------------------------------------------
module audio_i2s_tx #(
  parameter int DATA_SIZE   = 32,
  parameter int SAMPLE_BITS = 16,
  parameter int BCLK_DIV    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] left_audio_dout,
  input  logic                 left_audio_empty,
  output logic                 left_audio_rd_en,
  input  logic [DATA_SIZE-1:0] right_audio_dout,
  input  logic                 right_audio_empty,
  output logic                 right_audio_rd_en,
  output logic                 i2s_bclk,
  output logic                 i2s_lrclk,
  output logic                 i2s_sdata,
  output logic                 active,
  output logic [15:0]          underrun_count
);

  localparam int FRAME_BITS = 2 * SAMPLE_BITS;
  localparam int DIV_W      = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  // lrclk leads the word by one bit: it rises on the left LSB and falls on
  // the right LSB.
  localparam logic [BIT_W-1:0] LR_FIRST = BIT_W'(SAMPLE_BITS - 1);
  localparam logic [BIT_W-1:0] LR_LAST  = BIT_W'(FRAME_BITS - 2);

  // Clamp a signed DATA_SIZE sample into the signed SAMPLE_BITS range. The
  // value fits when every bit from the sign bit down to bit SAMPLE_BITS-1 is
  // identical. Otherwise the sign selects the positive or negative limit.
  function automatic logic [SAMPLE_BITS-1:0] sat(input logic [DATA_SIZE-1:0] x);
    logic [DATA_SIZE-SAMPLE_BITS:0] top;
    logic [SAMPLE_BITS-1:0]         res;
    top = x[DATA_SIZE-1:SAMPLE_BITS-1];
    if ((&top) || !(|top)) begin
      res = x[SAMPLE_BITS-1:0];
    end else if (x[DATA_SIZE-1]) begin
      res = {1'b1, {(SAMPLE_BITS-1){1'b0}}};
    end else begin
      res = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
    end
    return res;
  endfunction

  // Registered state
  logic [DIV_W-1:0]       div_cnt_q,   div_cnt_d;
  logic                   bclk_q,      bclk_d;
  logic [BIT_W-1:0]       bit_cnt_q,   bit_cnt_d;
  logic                   lrclk_q,     lrclk_d;
  logic                   sdata_q,     sdata_d;
  logic [FRAME_BITS-1:0]  shift_q,     shift_d;
  logic [SAMPLE_BITS-1:0] hold_l_q,    hold_l_d;
  logic [SAMPLE_BITS-1:0] hold_r_q,    hold_r_d;
  logic                   hold_valid_q, hold_valid_d;
  logic                   active_q,    active_d;
  logic [15:0]            underrun_q,  underrun_d;

  // Combinational helpers
  logic                   div_wrap_s;
  logic                   fall_s;
  logic                   frame_wrap_s;
  logic                   pop_s;
  logic [FRAME_BITS-1:0]  frame_s;

  // Bit-clock divider: free-running count, bclk toggles on each wrap.
  always_comb begin
    div_wrap_s = (div_cnt_q == DIV_LAST);
    if (div_wrap_s) begin
      div_cnt_d = {DIV_W{1'b0}};
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      bclk_d    = bclk_q;
    end
    // The serial outputs advance only when bclk is about to fall.
    fall_s = div_wrap_s && bclk_q;
  end

  // Pop decision uses only the current-cycle empties, so rd_en is never
  // raised while either FIFO is empty and both FIFOs always pop together.
  always_comb begin
    pop_s = !hold_valid_q && !left_audio_empty && !right_audio_empty;
  end

  // Frame word presented at the frame boundary: the held pair or silence.
  always_comb begin
    if (hold_valid_q) begin
      frame_s = {hold_l_q, hold_r_q};
    end else begin
      frame_s = {FRAME_BITS{1'b0}};
    end
    frame_wrap_s = (bit_cnt_q == BIT_LAST);
  end

  // Serializer, frame loader, underrun counter and prefetch hold register.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    lrclk_d      = lrclk_q;
    sdata_d      = sdata_q;
    shift_d      = shift_q;
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    hold_valid_d = hold_valid_q;
    active_d     = active_q;
    underrun_d   = underrun_q;

    if (fall_s) begin
      if (frame_wrap_s) begin
        // New frame: the MSB goes out in this same bclk fall, and the rest of
        // the word waits in the shift register already shifted by one.
        bit_cnt_d = {BIT_W{1'b0}};
        sdata_d   = frame_s[FRAME_BITS-1];
        shift_d   = {frame_s[FRAME_BITS-2:0], 1'b0};
        if (hold_valid_q) begin
          hold_valid_d = 1'b0;
          active_d     = 1'b1;
        end else if (active_q && (underrun_q != 16'hFFFF)) begin
          underrun_d = underrun_q + 16'd1;
        end else begin
          underrun_d = underrun_q;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        sdata_d   = shift_q[FRAME_BITS-1];
        shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
      end
      lrclk_d = (bit_cnt_d >= LR_FIRST) && (bit_cnt_d <= LR_LAST);
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    // A pop only happens with an empty hold register, so it can never
    // collide with the hold-clear above. On a boundary in the same cycle the
    // frame goes out silent and this pair waits for the next frame.
    if (pop_s) begin
      hold_l_d     = sat(left_audio_dout);
      hold_r_d     = sat(right_audio_dout);
      hold_valid_d = 1'b1;
    end else begin
      hold_valid_d = hold_valid_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt_q    <= {DIV_W{1'b0}};
      bclk_q       <= 1'b0;
      bit_cnt_q    <= BIT_LAST;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      shift_q      <= {FRAME_BITS{1'b0}};
      hold_l_q     <= {SAMPLE_BITS{1'b0}};
      hold_r_q     <= {SAMPLE_BITS{1'b0}};
      hold_valid_q <= 1'b0;
      active_q     <= 1'b0;
      underrun_q   <= 16'h0000;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bclk_q       <= bclk_d;
      bit_cnt_q    <= bit_cnt_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      shift_q      <= shift_d;
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      hold_valid_q <= hold_valid_d;
      active_q     <= active_d;
      underrun_q   <= underrun_d;
    end
  end

  // The pop strobe must be combinational because the FIFOs are show-ahead,
  // so the data is captured in the same cycle. It is held off during reset.
  assign left_audio_rd_en  = pop_s && !reset;
  assign right_audio_rd_en = pop_s && !reset;

  assign i2s_bclk       = bclk_q;
  assign i2s_lrclk      = lrclk_q;
  assign i2s_sdata      = sdata_q;
  assign active         = active_q;
  assign underrun_count = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
module tb_audio_i2s_tx;

  localparam int DS = 32;
  localparam int SB = 16;
  localparam int FB = 2 * SB;
  localparam int D  = 2;

  logic          clock;
  logic          reset;
  logic [DS-1:0] left_audio_dout;
  logic          left_audio_empty;
  logic          left_audio_rd_en;
  logic [DS-1:0] right_audio_dout;
  logic          right_audio_empty;
  logic          right_audio_rd_en;
  logic          i2s_bclk;
  logic          i2s_lrclk;
  logic          i2s_sdata;
  logic          active;
  logic [15:0]   underrun_count;

  audio_i2s_tx #(.DATA_SIZE(DS), .SAMPLE_BITS(SB), .BCLK_DIV(D)) dut (
    .clock             (clock),
    .reset             (reset),
    .left_audio_dout   (left_audio_dout),
    .left_audio_empty  (left_audio_empty),
    .left_audio_rd_en  (left_audio_rd_en),
    .right_audio_dout  (right_audio_dout),
    .right_audio_empty (right_audio_empty),
    .right_audio_rd_en (right_audio_rd_en),
    .i2s_bclk          (i2s_bclk),
    .i2s_lrclk         (i2s_lrclk),
    .i2s_sdata         (i2s_sdata),
    .active            (active),
    .underrun_count    (underrun_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  // FIFO contents and the received frames, decoded from the serial line.
  logic [DS-1:0] lq[$];
  logic [DS-1:0] rq[$];
  logic [FB-1:0] obs_frames[$];
  logic [FB-1:0] obs_shift;

  // Reference model state: cycles since reset release and frame contents.
  int          cyc;
  bit          m_hold;
  bit          m_active;
  logic [15:0] m_under;
  logic [FB-1:0] m_pair;
  logic [FB-1:0] cur_frame;
  logic        exp_sdata;
  logic        exp_lr;
  int          n_pops;
  int          n_bclk_rise;
  int          n_lr_rise;
  logic        prev_bclk;
  logic        prev_lr;

  function automatic logic [SB-1:0] sat_ref(input logic [DS-1:0] v);
    longint x;
    x = longint'($signed(v));
    if (x > 64'sd32767) return 16'h7FFF;
    else if (x < -64'sd32768) return 16'h8000;
    else return v[SB-1:0];
  endfunction

  // One clock: present FIFO heads, check the pop strobe, then advance the
  // reference model and check every I2S output against it.
  task automatic tick();
    logic pop_l, pop_r, rst_now, exp_pop, exp_bclk;
    logic [DS-1:0] lv, rv, dummy;
    int n, b;
    @(negedge clock);
    left_audio_empty  = (lq.size() == 0);
    right_audio_empty = (rq.size() == 0);
    if (left_audio_empty) left_audio_dout = $urandom();
    else left_audio_dout = lq[0];
    if (right_audio_empty) right_audio_dout = $urandom();
    else right_audio_dout = rq[0];
    #1;
    exp_pop = !reset && !m_hold && !left_audio_empty && !right_audio_empty;
    n_checks++;
    if (left_audio_rd_en !== exp_pop || right_audio_rd_en !== exp_pop) begin
      n_errors++;
      $display("FAIL rd_en cyc=%0d got L=%b R=%b expected %b", cyc, left_audio_rd_en, right_audio_rd_en, exp_pop);
    end
    pop_l   = (left_audio_rd_en === 1'b1);
    pop_r   = (right_audio_rd_en === 1'b1);
    lv      = left_audio_dout;
    rv      = right_audio_dout;
    rst_now = reset;
    @(posedge clock);
    #1;
    if (rst_now) begin
      cyc = 0; m_hold = 0; m_active = 0; m_under = 16'h0000;
      cur_frame = '0; exp_sdata = 1'b0; exp_lr = 1'b0;
      obs_shift = '0; obs_frames.delete();
    end else begin
      cyc++;
      if (cyc % (2 * D) == 0) begin
        n = cyc / (2 * D) - 1;
        b = n % FB;
        if (b == 0) begin
          if (m_hold) begin
            cur_frame = m_pair; m_hold = 0; m_active = 1;
          end else begin
            cur_frame = '0;
            if (m_active && m_under != 16'hFFFF) m_under = m_under + 16'd1;
          end
        end
        exp_sdata = cur_frame[FB-1-b];
        exp_lr    = (b >= SB - 1) && (b <= FB - 2);
        obs_shift = {obs_shift[FB-2:0], i2s_sdata};
        if (b == FB - 1) obs_frames.push_back(obs_shift);
      end
      if (pop_l && pop_r) begin
        m_pair = {sat_ref(lv), sat_ref(rv)};
        m_hold = 1;
      end
    end
    if (pop_l && lq.size() > 0) dummy = lq.pop_front();
    if (pop_r && rq.size() > 0) dummy = rq.pop_front();
    if (pop_l && pop_r) n_pops++;
    exp_bclk = ((cyc / D) % 2) == 1;
    n_checks++;
    if (i2s_bclk !== exp_bclk) begin
      n_errors++;
      $display("FAIL bclk cyc=%0d got %b expected %b", cyc, i2s_bclk, exp_bclk);
    end
    n_checks++;
    if (i2s_lrclk !== exp_lr) begin
      n_errors++;
      $display("FAIL lrclk cyc=%0d got %b expected %b", cyc, i2s_lrclk, exp_lr);
    end
    n_checks++;
    if (i2s_sdata !== exp_sdata) begin
      n_errors++;
      $display("FAIL sdata cyc=%0d got %b expected %b", cyc, i2s_sdata, exp_sdata);
    end
    n_checks++;
    if (active !== m_active || underrun_count !== m_under) begin
      n_errors++;
      $display("FAIL status cyc=%0d got active=%b under=%0d expected %b/%0d", cyc, active, underrun_count, m_active, m_under);
    end
    if (!prev_bclk && i2s_bclk) n_bclk_rise++;
    if (!prev_lr && i2s_lrclk) n_lr_rise++;
    prev_bclk = i2s_bclk;
    prev_lr   = i2s_lrclk;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic wait_frames(input int nf, input int limit);
    for (int k = 0; k < limit && obs_frames.size() < nf; k++) tick();
    n_checks++;
    if (obs_frames.size() < nf) begin
      n_errors++;
      $display("FAIL frame_timeout got %0d frames expected %0d", obs_frames.size(), nf);
    end
  endtask

  task automatic test_reset();
    int b0, l0, p0;
    apply_reset(3);
    n_checks++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, active, left_audio_rd_en} !== 5'b0 || underrun_count !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_state got bclk=%b lr=%b sd=%b act=%b under=%0d expected all 0", i2s_bclk, i2s_lrclk, i2s_sdata, active, underrun_count);
    end
    b0 = n_bclk_rise; l0 = n_lr_rise; p0 = n_pops;
    repeat (256) tick();
    n_checks++;
    if (n_bclk_rise - b0 != 64) begin
      n_errors++;
      $display("FAIL idle_bclk_rises got %0d expected 64", n_bclk_rise - b0);
    end
    n_checks++;
    if (n_lr_rise - l0 != 2) begin
      n_errors++;
      $display("FAIL idle_lrclk_rises got %0d expected 2", n_lr_rise - l0);
    end
    n_checks++;
    if (obs_frames.size() != 2 || obs_frames[0] !== 32'h0 || obs_frames[1] !== 32'h0) begin
      n_errors++;
      $display("FAIL idle_frames got %0d frames expected 2 zero frames", obs_frames.size());
    end
    n_checks++;
    if (active !== 1'b0 || underrun_count !== 16'h0000 || n_pops != p0) begin
      n_errors++;
      $display("FAIL idle_status got act=%b under=%0d pops=%0d expected 0/0/0", active, underrun_count, n_pops - p0);
    end
  endtask

  task automatic test_single_pair();
    int p0;
    apply_reset(2);
    p0 = n_pops;
    lq.push_back(32'h00001234);
    rq.push_back(32'hFFFFABCD);
    wait_frames(2, 600);
    n_checks++;
    if (obs_frames[0] !== 32'h1234ABCD) begin
      n_errors++;
      $display("FAIL single_frame got %h expected 1234abcd", obs_frames[0]);
    end
    n_checks++;
    if (obs_frames[1] !== 32'h0) begin
      n_errors++;
      $display("FAIL single_next_zero got %h expected 0", obs_frames[1]);
    end
    n_checks++;
    if (underrun_count !== 16'd1 || active !== 1'b1 || n_pops - p0 != 1) begin
      n_errors++;
      $display("FAIL single_status got under=%0d act=%b pops=%0d expected 1/1/1", underrun_count, active, n_pops - p0);
    end
  endtask

  task automatic test_saturation();
    apply_reset(2);
    lq.push_back(32'h00012345); rq.push_back(32'hFFFF7FFF);
    lq.push_back(32'hFFFF8000); rq.push_back(32'h00007FFF);
    lq.push_back(32'h00008000); rq.push_back(32'hFFFF8001);
    wait_frames(3, 800);
    n_checks++;
    if (obs_frames[0] !== 32'h7FFF8000) begin
      n_errors++;
      $display("FAIL sat_clip got %h expected 7fff8000", obs_frames[0]);
    end
    n_checks++;
    if (obs_frames[1] !== 32'h80007FFF) begin
      n_errors++;
      $display("FAIL sat_limits got %h expected 80007fff", obs_frames[1]);
    end
    n_checks++;
    if (obs_frames[2] !== 32'h7FFF8001) begin
      n_errors++;
      $display("FAIL sat_edge got %h expected 7fff8001", obs_frames[2]);
    end
  endtask

  task automatic test_mismatched_fill();
    int p0;
    apply_reset(2);
    p0 = n_pops;
    lq.push_back(32'h00000055);
    repeat (200) tick();
    n_checks++;
    if (n_pops != p0 || lq.size() != 1) begin
      n_errors++;
      $display("FAIL one_sided_pop got pops=%0d lq=%0d expected 0/1", n_pops - p0, lq.size());
    end
    rq.push_back(32'h000000AA);
    for (int k = 0; k < 5 && n_pops == p0; k++) tick();
    n_checks++;
    if (n_pops - p0 != 1 || lq.size() != 0 || rq.size() != 0) begin
      n_errors++;
      $display("FAIL joint_pop got pops=%0d lq=%0d rq=%0d expected 1/0/0", n_pops - p0, lq.size(), rq.size());
    end
  endtask

  task automatic test_stream();
    logic [DS-1:0] sl[8];
    logic [DS-1:0] sr[8];
    logic [FB-1:0] ef;
    int p0, s;
    apply_reset(2);
    p0 = n_pops;
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 2))
        0: begin s = int'($urandom_range(0, 65535)) - 32768; sl[k] = s; end
        1: sl[k] = $urandom();
        default: begin s = int'($urandom_range(0, 8)) + 32764; sl[k] = ($urandom_range(0, 1) == 1) ? s : -s; end
      endcase
      sr[k] = $urandom();
      if ({sat_ref(sl[k]), sat_ref(sr[k])} == 32'h0) sl[k] = 32'h1;
      lq.push_back(sl[k]);
      rq.push_back(sr[k]);
    end
    wait_frames(8, 1400);
    for (int k = 0; k < 8; k++) begin
      ef = {sat_ref(sl[k]), sat_ref(sr[k])};
      n_checks++;
      if (obs_frames[k] !== ef) begin
        n_errors++;
        $display("FAIL stream_frame%0d got %h expected %h", k, obs_frames[k], ef);
      end
    end
    n_checks++;
    if (underrun_count !== 16'h0000 || n_pops - p0 != 8) begin
      n_errors++;
      $display("FAIL stream_status got under=%0d pops=%0d expected 0/8", underrun_count, n_pops - p0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    apply_reset(2);
    lq.push_back(32'h00000111); rq.push_back(32'h00000222);
    lq.push_back(32'h00000333); rq.push_back(32'h00000444);
    repeat (84) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, active} !== 4'b0 || underrun_count !== 16'h0000) begin
      n_errors++;
      $display("FAIL midreset_state got bclk=%b lr=%b sd=%b act=%b under=%0d expected all 0", i2s_bclk, i2s_lrclk, i2s_sdata, active, underrun_count);
    end
    p0 = n_pops;
    repeat (300) tick();
    n_checks++;
    if (active !== 1'b0 || n_pops != p0 || obs_frames.size() != 2 || obs_frames[0] !== 32'h0 || obs_frames[1] !== 32'h0) begin
      n_errors++;
      $display("FAIL hold_discarded got act=%b pops=%0d frames=%0d expected 0/0/2 zero", active, n_pops - p0, obs_frames.size());
    end
    lq.push_back(32'hFFFFF00D); rq.push_back(32'h00007ABC);
    wait_frames(4, 800);
    n_checks++;
    if (obs_frames[2] !== 32'h0 || obs_frames[3] !== 32'hF00D7ABC) begin
      n_errors++;
      $display("FAIL post_reset_pair got %h %h expected 0 f00d7abc", obs_frames[2], obs_frames[3]);
    end
    n_checks++;
    if (active !== 1'b1 || n_pops - p0 != 1) begin
      n_errors++;
      $display("FAIL post_reset_status got act=%b pops=%0d expected 1/1", active, n_pops - p0);
    end
  endtask

  initial begin
    reset = 1'b1;
    left_audio_dout = '0; right_audio_dout = '0;
    left_audio_empty = 1'b1; right_audio_empty = 1'b1;
    cyc = 0; m_hold = 0; m_active = 0; m_under = 16'h0000;
    m_pair = '0; cur_frame = '0; exp_sdata = 1'b0; exp_lr = 1'b0;
    obs_shift = '0; n_pops = 0; n_bclk_rise = 0; n_lr_rise = 0;
    prev_bclk = 1'b0; prev_lr = 1'b0;
    test_reset();
    test_single_pair();
    test_saturation();
    test_mismatched_fill();
    test_stream();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
